// File: rtl/mem_burst_ctrl_if.sv
// Bundles the command, the two data streams and the memory pins of mem_burst_ctrl.
//   master : the side that issues commands, drives the write stream, accepts the read
//            stream and returns memory read data (testbench / host + memory)
//   slave  : the burst controller itself
// Signals: start/op/base_addr/len (command), busy/done (status),
//          in_valid/in_ready/in_data (write stream), out_valid/out_ready/out_data
//          (read stream), mem_wr/mem_addr/mem_din/mem_dout (memory pins).
interface mem_burst_ctrl_if #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int LW = 7
);
    logic          start;
    logic          op;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        output start, op, base_addr, len, in_valid, in_data, out_ready, mem_dout,
        input  busy, done, in_ready, out_valid, out_data, mem_wr, mem_addr, mem_din
    );

    modport slave (
        input  start, op, base_addr, len, in_valid, in_data, out_ready, mem_dout,
        output busy, done, in_ready, out_valid, out_data, mem_wr, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a 64x8 single-port synchronous memory. One command
// (op, base address, length) becomes a run of consecutive memory accesses; write data
// comes from a valid/ready stream, read data leaves on a valid/ready stream.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-low reset
//   if_bus   mem_burst_ctrl_if.slave (command, status, streams, memory pins)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; latches base address and saturated length
// S_WRITE    | one memory write per accepted write-stream beat
// S_RD_ISSUE | read address presented to the memory
// S_RD_WAIT  | memory dout valid, captured into the output register
// S_RD_OUT   | read beat offered on the output stream until taken
// S_FIN      | one-cycle done pulse, then back to idle
module mem_burst_ctrl #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int LW = 7
) (
    input logic             i_clk,
    input logic             i_reset,
    mem_burst_ctrl_if.slave if_bus
);

    localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);
    localparam logic [LW-1:0] ONE_LEN = LW'(1);
    localparam logic [AW-1:0] ONE_ADR = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_FIN
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_cnt;
    logic [DW-1:0] r_out_data;
    logic [LW-1:0] w_len_sat;
    logic          w_last;
    logic          w_busy;
    logic          w_done;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_mem_wr;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_din;

    assign w_len_sat = (if_bus.len > MAX_LEN) ? MAX_LEN : if_bus.len;
    // <= rather than == keeps a corrupted zero count from hanging the burst
    assign w_last    = (r_cnt <= ONE_LEN);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (if_bus.start) begin
                        r_addr <= if_bus.base_addr;
                        r_cnt  <= w_len_sat;
                    end
                end
                S_WRITE: begin
                    if (if_bus.in_valid && (r_cnt != '0)) begin
                        r_addr <= r_addr + ONE_ADR;
                        r_cnt  <= r_cnt - ONE_LEN;
                    end
                end
                S_RD_WAIT: begin
                    r_out_data <= if_bus.mem_dout;
                end
                S_RD_OUT: begin
                    if (if_bus.out_ready && (r_cnt != '0)) begin
                        r_addr <= r_addr + ONE_ADR;
                        r_cnt  <= r_cnt - ONE_LEN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_addr   = r_addr;
        w_mem_din    = '0;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_mem_addr = '0;
                if (if_bus.start) begin
                    if (w_len_sat == '0)
                        w_next_state = S_FIN;
                    else if (if_bus.op)
                        w_next_state = S_RD_ISSUE;
                    else
                        w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_in_ready = 1'b1;
                w_mem_wr   = if_bus.in_valid;
                w_mem_din  = if_bus.in_data;
                if (if_bus.in_valid && w_last)
                    w_next_state = S_FIN;
            end
            S_RD_ISSUE: w_next_state = S_RD_WAIT;
            S_RD_WAIT:  w_next_state = S_RD_OUT;
            S_RD_OUT: begin
                w_out_valid = 1'b1;
                if (if_bus.out_ready)
                    w_next_state = w_last ? S_FIN : S_RD_ISSUE;
            end
            S_FIN: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign if_bus.busy      = w_busy;
    assign if_bus.done      = w_done;
    assign if_bus.in_ready  = w_in_ready;
    assign if_bus.out_valid = w_out_valid;
    assign if_bus.out_data  = r_out_data;
    assign if_bus.mem_wr    = w_mem_wr;
    assign if_bus.mem_addr  = w_mem_addr;
    assign if_bus.mem_din   = w_mem_din;

endmodule
